// File: rtl/matmul_tile_sched.sv
// Tile-loop sequencer for the systolic matmul core: walks every output tile of
// C = I x W in row-major order, stepping k innermost, and drives BRAM reads and core control.
module matmul_tile_sched #(
  parameter int INNER_DIMENSION   = 4,
  parameter int BLOCK_SIZE        = 2,
  parameter int I_OUTER_DIMENSION = 6,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int ADDR_WIDTH        = 14,
  parameter int IDX_WIDTH         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic                  in_enb,
  output logic [ADDR_WIDTH-1:0] in_addrb,
  output logic                  wb_enb,
  output logic [ADDR_WIDTH-1:0] wb_addrb,
  output logic                  core_en,
  output logic                  core_rst_n,
  output logic                  acc_clr,
  input  logic                  systolic_finish,
  input  logic                  accumulator_done,
  output logic                  tile_valid,
  output logic [IDX_WIDTH-1:0]  tile_row,
  output logic [IDX_WIDTH-1:0]  tile_col
);

  localparam int K_TILES   = INNER_DIMENSION / BLOCK_SIZE;
  localparam int ROW_TILES = I_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int COL_TILES = W_OUTER_DIMENSION / BLOCK_SIZE;

  localparam logic [IDX_WIDTH-1:0]  K_LAST    = IDX_WIDTH'(K_TILES - 1);
  localparam logic [IDX_WIDTH-1:0]  ROW_LAST  = IDX_WIDTH'(ROW_TILES - 1);
  localparam logic [IDX_WIDTH-1:0]  COL_LAST  = IDX_WIDTH'(COL_TILES - 1);
  localparam logic [ADDR_WIDTH-1:0] K_TILES_A = ADDR_WIDTH'(K_TILES);

  if (K_TILES < 1 ||
      (INNER_DIMENSION % BLOCK_SIZE) != 0 ||
      (I_OUTER_DIMENSION % BLOCK_SIZE) != 0 ||
      (W_OUTER_DIMENSION % BLOCK_SIZE) != 0) begin : g_bad_params
    $error("matmul_tile_sched: dimensions must be non-zero multiples of BLOCK_SIZE");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_WAIT_ACC,
    S_TILE_DONE,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [IDX_WIDTH-1:0] k, row, col;
  logic                 k_last, row_last, col_last;

  assign k_last   = (k == K_LAST);
  assign row_last = (row == ROW_LAST);
  assign col_last = (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            k   <= '0;
            row <= '0;
            col <= '0;
          end
        end
        S_RUN: begin
          if (systolic_finish && !k_last) k <= k + 1'b1;
        end
        S_TILE_DONE: begin
          k <= '0;
          // On the final tile both indices wrap so they never exceed their limits.
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_FINISH: row <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH:     state_nxt = S_RUN;
      S_RUN: begin
        if (systolic_finish) begin
          if (!k_last)               state_nxt = S_FETCH;
          else if (accumulator_done) state_nxt = S_TILE_DONE;
          else                       state_nxt = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC:  if (accumulator_done) state_nxt = S_TILE_DONE;
      S_TILE_DONE: state_nxt = (row_last && col_last) ? S_FINISH : S_FETCH;
      S_FINISH:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Addresses follow the counters, so they stay put through RUN until k advances.
  always_comb begin
    ready      = 1'b0;
    done       = 1'b0;
    in_enb     = 1'b0;
    wb_enb     = 1'b0;
    core_en    = 1'b0;
    core_rst_n = 1'b0;
    acc_clr    = 1'b0;
    tile_valid = 1'b0;
    in_addrb   = ADDR_WIDTH'(k) + K_TILES_A * ADDR_WIDTH'(row);
    wb_addrb   = ADDR_WIDTH'(k) + K_TILES_A * ADDR_WIDTH'(col);
    tile_row   = row;
    tile_col   = col;
    case (state)
      S_IDLE: begin
        ready   = 1'b1;
        acc_clr = start;
      end
      S_FETCH: begin
        in_enb = 1'b1;
        wb_enb = 1'b1;
      end
      S_RUN: begin
        core_en    = 1'b1;
        core_rst_n = 1'b1;
      end
      S_TILE_DONE: begin
        tile_valid = 1'b1;
        acc_clr    = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule
